sync_fifo_prog: RTL



---
 rtl/sync_fifo_prog_pkg.sv | 21 ++
 rtl/fifo_defs.vh | 14 +
 rtl/fifo_mem.sv | 32 +++
 rtl/sync_fifo_prog.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/sync_fifo_prog_pkg.sv
// Shared definitions for sync_fifo_prog.
//   - default geometry, taken from fifo_defs.vh
//   - fifo_op_e: the accepted-access combination for one cycle.
//     Its bit layout is {write accepted, read accepted}.
// Optional feature macro (see fifo_defs.vh): FIFO_FWFT_EN
`include "fifo_defs.vh"

package sync_fifo_prog_pkg;

    localparam int DEF_WIDTH     = `FIFO_DEF_WIDTH;
    localparam int DEF_DEPTH     = `FIFO_DEF_DEPTH;
    localparam int DEF_PTR_WIDTH = `FIFO_DEF_PTR_WIDTH;

    typedef enum logic [1:0] {
        OP_IDLE  = 2'b00,
        OP_RD    = 2'b01,
        OP_WR    = 2'b10,
        OP_WR_RD = 2'b11
    } fifo_op_e;

endpackage

// File: rtl/fifo_defs.vh
// Default geometry shared by the FIFO package and anything else that needs it.
//
// Optional feature macro:
//   FIFO_FWFT_EN - when defined, the FIFO runs in first-word-fall-through mode.
//                  rdata_o is then a combinational view of the head entry.
//                  When undefined, rdata_o is registered with one cycle of read latency.
`ifndef FIFO_DEFS_VH
`define FIFO_DEFS_VH

`define FIFO_DEF_WIDTH     8
`define FIFO_DEF_DEPTH     16
`define FIFO_DEF_PTR_WIDTH 4

`endif

// File: rtl/fifo_mem.sv
// Simple dual-port register array used as FIFO storage.
//   clk   - write clock (rising edge)
//   we    - write enable
//   waddr - write address
//   wdata - write data
//   raddr - read address
//   rdata - read data (asynchronous, combinational from raddr)
// Contents are intentionally not reset.
module fifo_mem #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_prog.sv
// Parametrised single-clock FIFO.
// Features:
//   - occupancy count
//   - programmable almost-full / almost-empty flags
//   - synchronous flush
//   - overflow / underflow error pulses
// Ports:
//   clk_i, rst_i         - clock; asynchronous active-high reset
//   wr_en_i, wdata_i     - write request and data
//   full_o               - count == DEPTH
//   almost_full_o        - count >= AF_THRESH
//   wr_error_o           - one-cycle pulse after a rejected write
//   rd_en_i, rdata_o     - read request and data
//   empty_o              - count == 0
//   almost_empty_o       - count <= AE_THRESH
//   rd_error_o           - one-cycle pulse after a rejected read
//   flush_i              - synchronous clear of contents
//   count_o              - occupancy, 0..DEPTH
// Optional feature macro: FIFO_FWFT_EN.
//   Defined: rdata_o shows the head entry combinationally.
//   Undefined: rdata_o is registered and updates on each accepted read.
module sync_fifo_prog
    import sync_fifo_prog_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int PTR_WIDTH = DEF_PTR_WIDTH,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 wr_en_i,
    input  logic [WIDTH-1:0]     wdata_i,
    output logic                 full_o,
    output logic                 almost_full_o,
    output logic                 wr_error_o,
    input  logic                 rd_en_i,
    output logic [WIDTH-1:0]     rdata_o,
    output logic                 empty_o,
    output logic                 almost_empty_o,
    output logic                 rd_error_o,
    input  logic                 flush_i,
    output logic [PTR_WIDTH:0]   count_o
);

    typedef logic [PTR_WIDTH:0] ptr_t;

    localparam ptr_t PTR_ONE = ptr_t'(1);
    localparam ptr_t AF_C    = ptr_t'(AF_THRESH);
    localparam ptr_t AE_C    = ptr_t'(AE_THRESH);

    // Pointers carry an extra wrap bit above the index.
    ptr_t wr_ptr, rd_ptr, count_q;
    ptr_t wr_ptr_nxt, rd_ptr_nxt, count_nxt;

    logic             wr_acc, rd_acc;
    logic             full_nxt, empty_nxt, af_nxt, ae_nxt;
    logic             wr_err_nxt, rd_err_nxt;
    logic [WIDTH-1:0] mem_rdata;
    fifo_op_e         op;

    // A full FIFO still takes a write when a read frees a slot in the same cycle.
    // Flush overrides both requests.
    assign wr_acc = wr_en_i && (!full_o || rd_en_i) && !flush_i;
    assign rd_acc = rd_en_i && !empty_o && !flush_i;
    assign op     = fifo_op_e'({wr_acc, rd_acc});

    always_comb begin
        wr_ptr_nxt = wr_ptr;
        rd_ptr_nxt = rd_ptr;
        count_nxt  = count_q;
        if (flush_i) begin
            wr_ptr_nxt = '0;
            rd_ptr_nxt = '0;
            count_nxt  = '0;
        end else begin
            if (wr_acc) wr_ptr_nxt = wr_ptr + PTR_ONE;
            if (rd_acc) rd_ptr_nxt = rd_ptr + PTR_ONE;
            case (op)
                OP_WR:   count_nxt = count_q + PTR_ONE;
                OP_RD:   count_nxt = count_q - PTR_ONE;
                default: count_nxt = count_q;
            endcase
        end
    end

    // Flags are computed from next-state values so they line up with count_o.
    assign full_nxt   = (wr_ptr_nxt[PTR_WIDTH-1:0] == rd_ptr_nxt[PTR_WIDTH-1:0]) &&
                        (wr_ptr_nxt[PTR_WIDTH] != rd_ptr_nxt[PTR_WIDTH]);
    assign empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
    assign af_nxt     = (count_nxt >= AF_C);
    assign ae_nxt     = (count_nxt <= AE_C);
    assign wr_err_nxt = wr_en_i && !wr_acc && !flush_i;
    assign rd_err_nxt = rd_en_i && !rd_acc && !flush_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            count_q        <= '0;
            full_o         <= 1'b0;
            empty_o        <= 1'b1;
            almost_full_o  <= 1'b0;
            almost_empty_o <= 1'b1;
            wr_error_o     <= 1'b0;
            rd_error_o     <= 1'b0;
        end else begin
            wr_ptr         <= wr_ptr_nxt;
            rd_ptr         <= rd_ptr_nxt;
            count_q        <= count_nxt;
            full_o         <= full_nxt;
            empty_o        <= empty_nxt;
            almost_full_o  <= af_nxt;
            almost_empty_o <= ae_nxt;
            wr_error_o     <= wr_err_nxt;
            rd_error_o     <= rd_err_nxt;
        end
    end

    assign count_o = count_q;

    fifo_mem #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_mem (
        .clk   (clk_i),
        .we    (wr_acc),
        .waddr (wr_ptr[PTR_WIDTH-1:0]),
        .wdata (wdata_i),
        .raddr (rd_ptr[PTR_WIDTH-1:0]),
        .rdata (mem_rdata)
    );

`ifdef FIFO_FWFT_EN
    // The head entry is always visible; rd_en_i only advances past it.
    assign rdata_o = mem_rdata;
`else
    // Captures the head as it is popped, and holds on idle, rejected or flushed cycles.
    logic [WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (rd_acc) begin
            rdata_q <= mem_rdata;
        end
    end

    assign rdata_o = rdata_q;
`endif

endmodule
